// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
package seg7_scan_ctrl_pkg;

   // 1 ms per digit with the 100 MHz board clock
   localparam int unsigned DEFAULT_PRESCALE = 100000;

   typedef logic [6:0] glyph_t;

   localparam glyph_t SEG_DASH = 7'h40;

   // {g,f,e,d,c,b,a} for hex digits 0..F, entry 0 at the low end
   localparam logic [15:0][6:0] SEG_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic glyph_t seg_font(input logic [3:0] nib);
      return SEG_FONT[nib];
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_bin2bcd.sv
// Sequential double-dabble: one input bit per cycle, busy for exactly IN_W cycles.
// done is high during the last busy cycle, when bcd already holds the result.
module bin2bcd_seq #(
   parameter int unsigned IN_W  = 26,
   parameter int unsigned BCD_N = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [IN_W-1:0]      bin,
   output logic                 busy,
   output logic                 done,
   output logic [4*BCD_N-1:0]   bcd
);

   localparam int unsigned BCD_W = 4 * BCD_N;
   localparam int unsigned CNT_W = $clog2(IN_W + 1);

   logic [IN_W-1:0]  shreg;
   logic [CNT_W-1:0] cnt;
   logic [BCD_W-1:0] adj_c;

   // add-3 correction on every BCD digit that would overflow when doubled
   always_comb begin
      adj_c = bcd;
      for (int i = 0; i < BCD_N; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // the first shift happens on the start edge, so the result is ready one cycle before busy drops
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         shreg <= '0;
         bcd   <= '0;
      end else if (!busy) begin
         done <= 1'b0;
         if (start) begin
            busy  <= 1'b1;
            bcd   <= BCD_W'(bin[IN_W-1]);
            shreg <= bin << 1;
            cnt   <= CNT_W'(IN_W - 1);
            done  <= (IN_W == 1);
         end
      end else if (done) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         bcd   <= {adj_c[BCD_W-2:0], shreg[IN_W-1]};
         shreg <= shreg << 1;
         cnt   <= cnt - 1'b1;
         done  <= (cnt == CNT_W'(1));
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment controller: hex or decimal load, per-digit blank/dp masks,
// leading-zero suppression and overflow dashes.
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
   parameter int unsigned DEC_W    = 26
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [4*DIGITS-1:0]   wdata,
   input  logic                  wmode,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic                  busy,
   output logic                  ovf,
   output logic [DIGITS-1:0]     dig_en,
   output logic [7:0]            seg
);

   localparam int unsigned BCD_N = DIGITS + 4;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(PRESCALE);

   logic [PRE_W-1:0]        presc;
   logic [IDX_W-1:0]        idx;
   logic [DIGITS-1:0][3:0]  nib;
   logic [DIGITS-1:0]       blank_r;
   logic [DIGITS-1:0]       dp_r;
   logic                    lz_r;
   logic                    dec_r;
   logic                    conv_done;
   logic [4*BCD_N-1:0]      conv_bcd;
   logic                    load_hex_c;
   logic                    load_dec_c;
   logic                    tc_c;
   logic                    suppress_c;
   logic                    lit_c;
   glyph_t                  glyph_c;

   assign load_hex_c = wr_en && !busy && !wmode;
   assign load_dec_c = wr_en && !busy && wmode;
   assign tc_c       = (presc == PRE_W'(PRESCALE - 1));

   bin2bcd_seq #(
      .IN_W  (DEC_W),
      .BCD_N (BCD_N)
   ) u_conv (
      .clock (clock),
      .reset (reset),
      .start (load_dec_c),
      .bin   (wdata[DEC_W-1:0]),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // digit scan timing
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (tc_c) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // display contents; masks follow any accepted write, nibbles wait for the converter in decimal mode
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nib     <= '0;
         blank_r <= '0;
         dp_r    <= '0;
         lz_r    <= 1'b0;
         dec_r   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (load_hex_c) begin
            nib     <= wdata;
            blank_r <= blank_mask;
            dp_r    <= dp_mask;
            lz_r    <= lz_en;
            dec_r   <= 1'b0;
            ovf     <= 1'b0;
         end else if (load_dec_c) begin
            blank_r <= blank_mask;
            dp_r    <= dp_mask;
            lz_r    <= lz_en;
         end
         if (conv_done) begin
            nib   <= conv_bcd[4*DIGITS-1:0];
            dec_r <= 1'b1;
            ovf   <= |conv_bcd[4*BCD_N-1:4*DIGITS];
         end
      end
   end

   // a digit is suppressed when it and every digit above it are zero
   always_comb begin
      suppress_c = lz_r && dec_r && !ovf && (idx != '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (IDX_W'(i) >= idx && nib[i] != 4'd0) suppress_c = 1'b0;
      end
      lit_c   = !blank_r[idx] && !suppress_c;
      glyph_c = ovf ? SEG_DASH : seg_font(nib[idx]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dig_en <= '0;
         seg    <= '0;
      end else if (lit_c) begin
         dig_en <= DIGITS'(1) << idx;
         seg    <= {dp_r[idx], glyph_c};
      end else begin
         dig_en <= '0;
         seg    <= '0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIGITS=4, PRESCALE=4, DEC_W=14.
module tb_seg7_scan_ctrl;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;
   localparam int DEC_W    = 14;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wdata = '0;
   logic        wmode = 1'b0;
   logic        lz_en = 1'b0;
   logic [3:0]  blank_mask = '0;
   logic [3:0]  dp_mask = '0;
   logic        busy;
   logic        ovf;
   logic [3:0]  dig_en;
   logic [7:0]  seg;

   typedef struct {
      int         digit;
      int         nb;
      logic [3:0] en;
      logic [7:0] seg;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         mon_c;
   int         mon_d;
   int         nbusy;
   logic [7:0] hold_seg[4];

   seg7_scan_ctrl #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE),
      .DEC_W    (DEC_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .wdata      (wdata),
      .wmode      (wmode),
      .lz_en      (lz_en),
      .blank_mask (blank_mask),
      .dp_mask    (dp_mask),
      .busy       (busy),
      .ovf        (ovf),
      .dig_en     (dig_en),
      .seg        (seg)
   );

   always #5 clock = ~clock;

   // edges since reset release; digit d is displayed after edges 4k+1..4k+4 with k%4==d
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int d, input logic [3:0] en, input logic [7:0] s);
      exp_t e;
      e.digit = d;
      e.nb    = cyc;
      e.en    = en;
      e.seg   = s;
      sb.push_back(e);
   endtask

   task automatic push_lit(input int d, input logic [7:0] s);
      push(d, 4'(1) << d, s);
   endtask

   task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      push_lit(0, s0);
      push_lit(1, s1);
      push_lit(2, s2);
      push_lit(3, s3);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic hex_load(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dp);
      @(negedge clock);
      wr_en = 1'b1; wmode = 1'b0; wdata = v; blank_mask = bl; dp_mask = dp; lz_en = 1'b0;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   // decimal load; counts busy cycles, optionally checks the held display and pokes a write mid-conversion
   task automatic dec_load(input logic [15:0] v, input logic lz, input logic [3:0] bl,
                           input logic [3:0] dp, input bit hold, input bit poke, output int n);
      int d;
      @(negedge clock);
      wr_en = 1'b1; wmode = 1'b1; wdata = v; lz_en = lz; blank_mask = bl; dp_mask = dp;
      @(negedge clock);
      wr_en = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         if (hold && n >= 1) begin
            d = ((cyc - 1) / PRESCALE) % DIGITS;
            check("hold_en", 32'(dig_en), 32'(4'(1) << d));
            check("hold_seg", 32'(seg), 32'(hold_seg[d]));
         end
         if (poke && n == 3) begin
            wr_en = 1'b1; wmode = 1'b1; wdata = 16'd99; lz_en = 1'b1; blank_mask = 4'hF;
         end else begin
            wr_en = 1'b0; wmode = 1'b0;
         end
         n++;
         @(negedge clock);
      end
      wr_en = 1'b0;
   endtask

   // monitor: compares the front entry at the first and last cycle of its digit's slot
   always @(negedge clock) begin
      if (!reset && sb.size() != 0) begin
         mon_c = cyc;
         mon_d = ((mon_c - 1) / PRESCALE) % DIGITS;
         if (mon_c - 1 >= sb[0].nb && mon_d == sb[0].digit &&
             (mon_c % PRESCALE == 1 || mon_c % PRESCALE == 0)) begin
            check($sformatf("scan_en_d%0d", mon_d), 32'(dig_en), 32'(sb[0].en));
            check($sformatf("scan_seg_d%0d", mon_d), 32'(seg), 32'(sb[0].seg));
            if (mon_c % PRESCALE == 0) void'(sb.pop_front());
         end else if (mon_c > sb[0].nb + 4 * DIGITS * PRESCALE) begin
            n_cmp++;
            n_err++;
            $display("FAIL scan_timeout: digit %0d never shown, want it within %0d cycles",
                     sb[0].digit, 4 * DIGITS * PRESCALE);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset release and first edge
      repeat (2) @(negedge clock);
      check("rst_dig_en", 32'(dig_en), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      #2 reset = 1'b0;
      @(negedge clock);
      check("first_dig_en", 32'(dig_en), 32'h1);
      check("first_seg", 32'(seg), 32'h3F);
      check("first_ovf", 32'(ovf), 32'h0);
      push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
      drain();

      // hex A81F, dp on digit 1
      hex_load(16'hA81F, 4'b0000, 4'b0010);
      check("hex_ovf", 32'(ovf), 32'h0);
      check("hex_busy", 32'(busy), 32'h0);
      push_frame(8'h71, 8'h86, 8'h7F, 8'h77);
      drain();

      // reset mid-scan: asynchronous clear, then restart from digit 0 showing '0'
      repeat (6) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_dig_en", 32'(dig_en), 32'h0);
      check("midrst_seg", 32'(seg), 32'h0);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check("rerel_dig_en", 32'(dig_en), 32'h1);
      check("rerel_seg", 32'(seg), 32'h3F);
      push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
      drain();

      // decimal 1234: display held (new dp mask already applied) for the 14 busy cycles
      hex_load(16'hA81F, 4'b0000, 4'b0010);
      hold_seg[0] = 8'h71; hold_seg[1] = 8'h06; hold_seg[2] = 8'h7F; hold_seg[3] = 8'h77;
      dec_load(16'd1234, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, nbusy);
      check("d1234_busy_cycles", 32'(nbusy), 32'd14);
      check("d1234_ovf", 32'(ovf), 32'h0);
      push_frame(8'h66, 8'h4F, 8'h5B, 8'h06);
      drain();

      // decimal 42 with leading-zero suppression
      dec_load(16'd42, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, nbusy);
      check("d42_busy_cycles", 32'(nbusy), 32'd14);
      push_lit(0, 8'h5B);
      push_lit(1, 8'h66);
      push(2, 4'h0, 8'h00);
      push(3, 4'h0, 8'h00);
      drain();

      dec_load(16'd42, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, nbusy);
      push(0, 4'h0, 8'h00);
      push_lit(1, 8'h66);
      push(2, 4'h0, 8'h00);
      push(3, 4'h0, 8'h00);
      drain();

      // decimal 12345 does not fit four digits
      dec_load(16'd12345, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, nbusy);
      check("d12345_busy_cycles", 32'(nbusy), 32'd14);
      check("d12345_ovf", 32'(ovf), 32'h1);
      push_frame(8'h40, 8'h40, 8'h40, 8'h40);
      drain();

      hex_load(16'h1234, 4'b0000, 4'b0000);
      check("hex_clears_ovf", 32'(ovf), 32'h0);
      push_frame(8'h66, 8'h4F, 8'h5B, 8'h06);
      drain();

      // a write during conversion is ignored
      dec_load(16'd56, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, nbusy);
      check("ignore_busy_cycles", 32'(nbusy), 32'd14);
      check("ignore_ovf", 32'(ovf), 32'h0);
      push_frame(8'h7D, 8'h6D, 8'h3F, 8'h3F);
      drain();

      // reset during conversion aborts it
      @(negedge clock);
      wr_en = 1'b1; wmode = 1'b1; wdata = 16'd9999; lz_en = 1'b0; blank_mask = '0; dp_mask = '0;
      @(negedge clock);
      wr_en = 1'b0;
      repeat (4) @(negedge clock);
      check("conv_busy_before_rst", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("conv_rst_busy", 32'(busy), 32'h0);
      check("conv_rst_dig_en", 32'(dig_en), 32'h0);
      check("conv_rst_seg", 32'(seg), 32'h0);
      check("conv_rst_ovf", 32'(ovf), 32'h0);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check("conv_rel_dig_en", 32'(dig_en), 32'h1);
      check("conv_rel_seg", 32'(seg), 32'h3F);
      check("conv_rel_busy", 32'(busy), 32'h0);
      push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. It replaces the fixed 4-digit scanner pair in the CPU top. Software writes a value through the IO bus as hex or unsigned decimal, and the block scans DIGITS digits with per-digit blank and decimal-point masks. Decimal mode uses an internal sequential binary-to-BCD converter with overflow indication and optional leading-zero suppression.

Parameters:
DIGITS, 8, number of digits scanned (1..8)
PRESCALE, 100000, clock cycles each digit stays lit (≥2)
DEC_W, 26, low value bits used in decimal mode; requires 2^DEC_W ≤ 10^(DIGITS+4)

Ports:
clock  in  1  system clock (clk1 domain)
reset  in  1  asynchronous, active-high reset
wr_en  in  1  load strobe, one cycle
wdata  in  4*DIGITS  value: hex nibbles, or unsigned binary in decimal mode
wmode  in  1  0 = hex, 1 = decimal
lz_en  in  1  leading-zero suppression (decimal mode only)
blank_mask  in  DIGITS  1 = digit forced dark
dp_mask  in  DIGITS  1 = decimal point lit on that digit
busy  out  1  decimal conversion in progress
ovf  out  1  last decimal value did not fit in DIGITS digits
dig_en  out  DIGITS  one-hot digit enable, active-high
seg  out  8  {dp,g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset (async, active-high):
  - prescaler, digit index, display nibbles, masks, busy, ovf all 0.
  - dig_en = 0, seg = 0 while reset is asserted.
  - A reset during a conversion aborts it.
- Load, hex mode (wr_en=1, wmode=0, busy=0):
  - Display nibbles, masks and lz flag update on the next edge.
  - ovf is cleared. No busy.
- Load, decimal mode (wr_en=1, wmode=1, busy=0):
  - Masks are captured immediately. wdata[DEC_W-1:0] goes into the converter.
  - busy=1 for exactly DEC_W cycles (double-dabble: add-3 then shift, one bit per cycle).
  - On the edge that drops busy, the BCD result loads into the display nibbles.
  - ovf is set if any BCD digit ≥ DIGITS is nonzero.
  - While ovf=1, every non-blanked digit shows '-' (seg[6:0]=7'h40).
  - The old display is held during conversion.
- wr_en while busy=1: ignored entirely. No queueing, no state change.
- Scan:
  - Prescaler counts 0..PRESCALE-1. At the terminal count the digit index advances (DIGITS-1 wraps to 0) and the prescaler returns to 0.
  - Outputs are registered from the index (1-cycle latency).
  - dig_en = one-hot(index), masked to 0 if blank_mask[index] or the digit is suppressed.
  - seg[6:0] = font(nibble[index]); seg[7] = dp_mask[index].
  - When dig_en is 0, seg = 0.
- Font: hex 0-F in standard pattern, e.g. 0=3F, 1=06, 8=7F, A=77, F=71.
- Leading-zero suppression: applies only when lz_en=1, decimal mode, ovf=0. Digits above the most significant nonzero digit are dark. Digit 0 is never suppressed.
- First cycle after reset release: dig_en=…0001, seg=8'h3F (digit 0 showing '0').
- Simultaneous terminal count and load: both take effect. The new digit shows the new data if the load completes that edge.

Decomposition:
- Shared package/definitions entries:
  - SEG_FONT 16-entry table.
  - SEG_DASH constant.
  - Default PRESCALE for the 100 MHz board clock.
- Sub-module bin2bcd_seq (params IN_W, BCD_N):
  - Ports: start, bin, busy, done, bcd.
  - Sequential double-dabble, one bit per cycle.
- Top level holds the prescaler, index, masks, suppression logic and output registers.

Test Plan:
- Reset mid-scan; release. Expect dig_en=0001 and seg=3F on the first edge, and the index advancing every PRESCALE cycles. Bench params: DIGITS=4, PRESCALE=4.
- Hex load 16'hA81F with dp_mask=0010 → digits 0..3 show seg 71, 86 (06|dp), 7F, 77. dig_en rotates 0001→0010→0100→1000→0001.
- Decimal load 1234, DEC_W=14, lz_en=1.
  - busy is high exactly 14 cycles; the display is unchanged until then.
  - Afterwards digits show 4, 3, 2, 1 and ovf=0.
- Decimal load 42 with lz_en=1 → digits 2 and 3 dark. With blank_mask=0001, digit 0 is also dark.
- Decimal load 12345 with DIGITS=4 → ovf=1 and all digits show seg 40. A following hex load clears ovf.
- wr_en pulse while busy → ignored; the final display matches the first value.
- Assert reset during conversion → busy=0 and outputs 0 immediately, asynchronously.
